// File: rtl/exit_zone_detector_if.sv
// Scan/pixel inputs and zone-code outputs of exit_zone_detector, grouped as one bundle.
interface exit_zone_detector_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic [9:0] PlayerX;
   logic [9:0] PlayerY;
   logic [1:0] pix_zone;
   logic [1:0] candidate;
   logic [1:0] color_main;
   logic       frame_done;

   modport master (
      output DrawX, DrawY, PlayerX, PlayerY, pix_zone,
      input  candidate, color_main, frame_done
   );

   modport slave (
      input  DrawX, DrawY, PlayerX, PlayerY, pix_zone,
      output candidate, color_main, frame_done
   );
endinterface

// File: rtl/exit_zone_detector.sv
// Counts zone-tagged pixels inside the player box each frame, picks a winner in vblank
// and debounces it across frames before publishing color_main.
module exit_zone_detector #(
   parameter int unsigned HALF          = 16,
   parameter int unsigned THRESH        = 8,
   parameter int unsigned STABLE_FRAMES = 2,
   parameter int unsigned PIX_LAT       = 1,
   parameter int unsigned CNT_W         = 10
) (
   input  logic                 vga_clk,
   input  logic                 Reset_n,
   exit_zone_detector_if.slave  bus
);

   localparam logic [1:0] ST_ACCUM  = 2'd0;
   localparam logic [1:0] ST_EVAL   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [9:0]       px_q, px_d;
   logic [9:0]       py_q, py_d;
   logic             prime_q, prime_d;
   logic [1:0]       cand_q, cand_d;
   logic [1:0]       prev_q, prev_d;
   logic [3:0]       stable_q, stable_d;
   logic [1:0]       main_q, main_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q [1:3];
   logic [CNT_W-1:0] cnt_d [1:3];

   logic             latch_now;
   logic             eval_now;
   logic             inbox;
   logic             hit_aligned;
   logic [1:0]       win;
   logic [CNT_W-1:0] best;

   assign latch_now = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd524);
   assign eval_now  = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd480);

   // 11-bit arithmetic keeps the box from wrapping past column 0 / row 0.
   logic [10:0] x11, y11, px11, py11, half11;
   assign x11    = {1'b0, bus.DrawX};
   assign y11    = {1'b0, bus.DrawY};
   assign px11   = {1'b0, px_q};
   assign py11   = {1'b0, py_q};
   assign half11 = 11'(HALF);

   assign inbox = (x11 + half11 >= px11) && (x11 <= px11 + half11) &&
                  (y11 + half11 >= py11) && (y11 <= py11 + half11) &&
                  (bus.DrawX < 10'd640) && (bus.DrawY < 10'd480);

   generate
      if (PIX_LAT == 0) begin : g_nodly
         assign hit_aligned = inbox;
      end else begin : g_dly
         logic [PIX_LAT-1:0] dly_q;
         always_ff @(posedge vga_clk or negedge Reset_n) begin
            if (!Reset_n) dly_q <= '0;
            else          dly_q <= (dly_q << 1) | PIX_LAT'(inbox);
         end
         assign hit_aligned = dly_q[PIX_LAT-1];
      end
   endgenerate

   // Later zones win ties through the >= comparison.
   always_comb begin
      win  = 2'd0;
      best = '0;
      for (int unsigned z = 1; z < 4; z++) begin
         if ((32'(cnt_q[z]) >= THRESH) && (cnt_q[z] >= best)) begin
            win  = 2'(z);
            best = cnt_q[z];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      px_d     = px_q;
      py_d     = py_q;
      prime_d  = prime_q;
      cand_d   = cand_q;
      prev_d   = prev_q;
      stable_d = stable_q;
      main_d   = main_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;

      if (latch_now) begin
         px_d    = bus.PlayerX;
         py_d    = bus.PlayerY;
         prime_d = 1'b1;
      end

      case (state_q)
         ST_ACCUM: begin
            if (hit_aligned && (bus.pix_zone != 2'd0) && (cnt_q[bus.pix_zone] != '1))
               cnt_d[bus.pix_zone] = cnt_q[bus.pix_zone] + CNT_W'(1);
            if (eval_now) state_d = ST_EVAL;
         end
         ST_EVAL: begin
            if (prime_q) cand_d = win;
            done_d  = 1'b1;
            state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            // An unprimed frame is partial: discard it without touching the debounce.
            if (prime_q) begin
               prev_d = cand_q;
               if (cand_q == prev_q)
                  stable_d = (stable_q == 4'hF) ? stable_q : stable_q + 4'd1;
               else
                  stable_d = 4'd1;
               if (32'(stable_d) >= STABLE_FRAMES) main_d = cand_q;
            end
            for (int unsigned z = 1; z < 4; z++) cnt_d[z] = '0;
            state_d = ST_ACCUM;
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge vga_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= ST_ACCUM;
         px_q     <= '0;
         py_q     <= '0;
         prime_q  <= 1'b0;
         cand_q   <= '0;
         prev_q   <= '0;
         stable_q <= '0;
         main_q   <= '0;
         done_q   <= 1'b0;
         for (int unsigned z = 1; z < 4; z++) cnt_q[z] <= '0;
      end else begin
         state_q  <= state_d;
         px_q     <= px_d;
         py_q     <= py_d;
         prime_q  <= prime_d;
         cand_q   <= cand_d;
         prev_q   <= prev_d;
         stable_q <= stable_d;
         main_q   <= main_d;
         done_q   <= done_d;
         for (int unsigned z = 1; z < 4; z++) cnt_q[z] <= cnt_d[z];
      end
   end

   assign bus.candidate  = cand_q;
   assign bus.color_main = main_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_exit_zone_detector.sv
// Directed bench for exit_zone_detector using compressed frames (only chosen pixels are scanned).
module tb_exit_zone_detector;

   logic vga_clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 vga_clk = ~vga_clk;

   exit_zone_detector_if bus ();
   exit_zone_detector_if bus4 ();

   assign bus4.DrawX    = bus.DrawX;
   assign bus4.DrawY    = bus.DrawY;
   assign bus4.PlayerX  = bus.PlayerX;
   assign bus4.PlayerY  = bus.PlayerY;
   assign bus4.pix_zone = bus.pix_zone;

   exit_zone_detector #(.HALF(16), .THRESH(8), .STABLE_FRAMES(2), .PIX_LAT(1), .CNT_W(10)) dut (
      .vga_clk (vga_clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   exit_zone_detector #(.HALF(16), .THRESH(8), .STABLE_FRAMES(2), .PIX_LAT(1), .CNT_W(4)) dut4 (
      .vga_clk (vga_clk),
      .Reset_n (Reset_n),
      .bus     (bus4)
   );

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   logic [1:0] pend_z = 2'd0;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   // pix_zone trails the coordinates by one cycle (PIX_LAT=1).
   task automatic pix(input int x, input int y, input logic [1:0] z);
      bus.DrawX    = 10'(x);
      bus.DrawY    = 10'(y);
      bus.pix_zone = pend_z;
      pend_z       = z;
      tick();
   endtask

   task automatic row(input int x0, input int n, input int y, input logic [1:0] z);
      for (int i = 0; i < n; i++) pix(x0 + i, y, z);
   endtask

   task automatic end_frame(input string tag, input logic [1:0] exp_cand, input logic [1:0] exp_main);
      pix(0, 480, 2'd0);
      check({tag, ".done_eval"}, {1'b0, bus.frame_done}, 2'd0);
      pix(1, 480, 2'd0);
      check({tag, ".cand"}, bus.candidate, exp_cand);
      check({tag, ".done"}, {1'b0, bus.frame_done}, 2'd1);
      pix(2, 480, 2'd0);
      check({tag, ".main"}, bus.color_main, exp_main);
      check({tag, ".done_off"}, {1'b0, bus.frame_done}, 2'd0);
   endtask

   task automatic latch(input int x, input int y);
      bus.PlayerX = 10'(x);
      bus.PlayerY = 10'(y);
      pix(0, 524, 2'd0);
      pix(1, 524, 2'd0);
   endtask

   initial begin
      bus.DrawX    = 10'd0;
      bus.DrawY    = 10'd0;
      bus.PlayerX  = 10'd0;
      bus.PlayerY  = 10'd0;
      bus.pix_zone = 2'd0;
      Reset_n      = 1'b0;
      tick(); tick(); tick();
      check("rst.main", bus.color_main, 2'd0);
      check("rst.cand", bus.candidate, 2'd0);
      check("rst.done", {1'b0, bus.frame_done}, 2'd0);

      // Release mid-frame; box is around (0,0) and 17 hits land, but the frame is unprimed.
      bus.DrawX = 10'd100;
      bus.DrawY = 10'd100;
      Reset_n   = 1'b1;
      tick();
      row(0, 20, 5, 2'd2);
      end_frame("unprimed", 2'd0, 2'd0);

      latch(320, 240);
      row(310, 20, 240, 2'd2);
      end_frame("steady1", 2'd2, 2'd0);
      latch(320, 240);
      row(310, 20, 240, 2'd2);
      end_frame("steady2", 2'd2, 2'd2);
      latch(320, 240);
      row(310, 20, 240, 2'd2);
      end_frame("steady3", 2'd2, 2'd2);

      latch(320, 240);
      for (int i = 0; i < 100; i++) pix(304 + (i % 33), 224 + (i / 33), 2'd1);
      for (int i = 0; i < 100; i++) pix(304 + (i % 33), 240 + (i / 33), 2'd3);
      end_frame("tie", 2'd3, 2'd2);

      latch(320, 240);
      row(310, 7, 240, 2'd1);
      end_frame("thresh1", 2'd0, 2'd2);
      latch(320, 240);
      row(310, 7, 240, 2'd1);
      end_frame("thresh2", 2'd0, 2'd0);

      // Player at column 5: box spans columns 0..21 only.
      latch(5, 240);
      row(14, 8, 240, 2'd1);
      end_frame("edge_hi_in", 2'd1, 2'd0);
      latch(5, 240);
      pix(22, 240, 2'd1);
      row(790, 10, 240, 2'd1);
      pix(320, 500, 2'd1);
      end_frame("edge_out", 2'd0, 2'd0);
      latch(5, 240);
      row(0, 8, 240, 2'd3);
      end_frame("edge_lo_in", 2'd3, 2'd0);

      // Player moves mid-frame; box must stay at the latched column 320.
      latch(320, 240);
      pix(0, 200, 2'd0);
      bus.PlayerX = 10'd100;
      row(310, 20, 240, 2'd2);
      row(90, 20, 240, 2'd3);
      end_frame("latch", 2'd2, 2'd0);
      bus.PlayerX = 10'd320;

      latch(320, 240);
      for (int y = 224; y <= 256; y++) row(304, 33, y, 2'd3);
      for (int i = 0; i < 10; i++) pix(320, 240, 2'd1);
      end_frame("sat", 2'd3, 2'd0);
      check("sat.cand4", bus4.candidate, 2'd3);

      latch(320, 240);
      row(310, 20, 240, 2'd3);
      end_frame("final", 2'd3, 2'd3);
      check("final.main4", bus4.color_main, 2'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
